// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder for the fetch port.
// A hit returns the instruction one cycle after the address is accepted.
// A miss stalls fetch and fills the whole line from a word-wide memory port,
// then delivers the requested word in a one-cycle DONE state.
module icache_responder #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  output logic [31:0] icache_dout,
  output logic        icache_stall,
  input  logic        invalidate,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = 30 - OFF_W - IDX_W;
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  // MISS is the lookup cycle that found no hit; it only exists to keep the
  // request one cycle after the stall appears.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MISS = 3'd1,
    ST_REQ  = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [29:0]       req_q_r;
  logic [OFF_W-1:0]  cnt_r;
  logic              pend_inv_r;
  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [31:0]       data_r [LINES*LINE_WORDS];

  logic [31:0]       dout_r;
  logic              stall_r;
  logic              req_valid_r;
  logic [31:0]       req_addr_r;

  logic              stall_next_s;
  logic              req_valid_next_s;

  logic [OFF_W-1:0]  a_off_s;
  logic [IDX_W-1:0]  a_idx_s;
  logic [TAG_W-1:0]  a_tag_s;
  logic [OFF_W-1:0]  q_off_s;
  logic [IDX_W-1:0]  q_idx_s;
  logic [TAG_W-1:0]  q_tag_s;
  logic              accept_s;
  logic              inv_now_s;
  logic              hit_s;
  logic              beat_s;
  logic              last_beat_s;
  logic [31:0]       fill_word_s;
  logic [1:0]        unused_addr_bits;

  assign unused_addr_bits = icache_addr[1:0];

  assign a_off_s = icache_addr[2 +: OFF_W];
  assign a_idx_s = icache_addr[IDX_LSB +: IDX_W];
  assign a_tag_s = icache_addr[TAG_LSB +: TAG_W];
  assign q_off_s = req_q_r[0 +: OFF_W];
  assign q_idx_s = req_q_r[OFF_W +: IDX_W];
  assign q_tag_s = req_q_r[OFF_W + IDX_W +: TAG_W];

  assign accept_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && icache_re;

  // An invalidate outside REQ/FILL takes effect at this edge; in DONE a
  // previously deferred invalidate is applied as well. A lookup registered
  // at the same edge must see the cleared state.
  assign inv_now_s = ((state_r == ST_IDLE) || (state_r == ST_MISS) || (state_r == ST_DONE)) &&
                     (invalidate || ((state_r == ST_DONE) && pend_inv_r));

  assign hit_s       = valid_r[a_idx_s] && (tag_r[a_idx_s] == a_tag_s) && !inv_now_s;
  assign beat_s      = (state_r == ST_FILL) && mem_resp_valid;
  assign last_beat_s = beat_s && (cnt_r == LAST_BEAT);

  // Earlier beats are already in the array; only the beat arriving now is not.
  assign fill_word_s = (q_off_s == cnt_r) ? mem_resp_data : data_r[{q_idx_s, q_off_s}];

  assign icache_dout   = dout_r;
  assign icache_stall  = stall_r;
  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = req_addr_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: lookup, request handshake, beat counting.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s && !hit_s) begin
          state_next_s = ST_MISS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MISS: begin
        state_next_s = ST_REQ;
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_FILL: begin
        if (last_beat_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    stall_next_s     = 1'b0;
    req_valid_next_s = 1'b0;
    case (state_next_s)
      ST_MISS, ST_FILL: begin
        stall_next_s     = 1'b1;
        req_valid_next_s = 1'b0;
      end
      ST_REQ: begin
        stall_next_s     = 1'b1;
        req_valid_next_s = 1'b1;
      end
      default: begin
        stall_next_s     = 1'b0;
        req_valid_next_s = 1'b0;
      end
    endcase
  end

  // Output registers: stall, request, fill address and returned instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r     <= 1'b0;
      req_valid_r <= 1'b0;
      req_addr_r  <= 32'h0000_0000;
      dout_r      <= 32'h0000_0000;
    end else begin
      stall_r     <= stall_next_s;
      req_valid_r <= req_valid_next_s;
      if (state_r == ST_MISS) begin
        req_addr_r <= {q_tag_s, q_idx_s, {(OFF_W + 2){1'b0}}};
      end else begin
        req_addr_r <= req_addr_r;
      end
      if (accept_s && hit_s) begin
        dout_r <= data_r[{a_idx_s, a_off_s}];
      end else if (last_beat_s) begin
        dout_r <= fill_word_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  // Control state: accepted address, beat counter, valid bits, deferred invalidate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q_r    <= 30'h0000_0000;
      cnt_r      <= '0;
      pend_inv_r <= 1'b0;
      valid_r    <= '0;
    end else begin
      if (accept_s) begin
        req_q_r <= icache_addr[31:2];
      end else begin
        req_q_r <= req_q_r;
      end

      if ((state_r == ST_REQ) && mem_req_ready) begin
        cnt_r <= '0;
      end else if (beat_s) begin
        cnt_r <= cnt_r + OFF_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      if (((state_r == ST_REQ) || (state_r == ST_FILL)) && invalidate) begin
        pend_inv_r <= 1'b1;
      end else if (state_r == ST_DONE) begin
        pend_inv_r <= 1'b0;
      end else begin
        pend_inv_r <= pend_inv_r;
      end

      if (inv_now_s) begin
        valid_r <= '0;
      end else if (last_beat_s) begin
        valid_r[q_idx_s] <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  // Data and tag arrays: plain synchronous-write storage, no reset needed
  // because nothing is read until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      data_r[{q_idx_s, cnt_r}] <= mem_resp_data;
    end
    if (last_beat_s) begin
      tag_r[q_idx_s] <= q_tag_s;
    end
  end

endmodule
